// File: rtl/cacheline_adapter.sv
// Cache line-fill/write-back responder: turns one full-line request into a
// multi-beat burst on banked burst memory and returns a single-cycle response.
module cacheline_adapter #(
  parameter int LINE_WIDTH = 256,
  parameter int BEAT_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           dfp_addr,
  input  logic                  dfp_read,
  input  logic                  dfp_write,
  input  logic [LINE_WIDTH-1:0] dfp_wdata,
  output logic [LINE_WIDTH-1:0] dfp_rdata,
  output logic                  dfp_resp,
  output logic [31:0]           bmem_addr,
  output logic                  bmem_read,
  output logic                  bmem_write,
  output logic [BEAT_WIDTH-1:0] bmem_wdata,
  input  logic                  bmem_ready,
  input  logic [BEAT_WIDTH-1:0] bmem_rdata,
  input  logic                  bmem_rvalid
);

  localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [31:0] ADDR_MASK = ~32'(LINE_WIDTH / 8 - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_DATA,
    WR_DATA,
    RESP
  } state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [CNT_W-1:0]      r_cnt;
  logic [31:0]           r_addr;
  logic [LINE_WIDTH-1:0] r_wline;
  logic [LINE_WIDTH-1:0] r_rbuf;
  logic [LINE_WIDTH-1:0] r_rline;
  logic [LINE_WIDTH-1:0] w_lineNext;
  logic                  w_beatDone;
  logic                  w_lastBeat;

  assign w_lastBeat = (r_cnt == LAST_BEAT);
  assign dfp_rdata  = r_rline;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_beatDone  = 1'b0;
    dfp_resp    = 1'b0;
    bmem_read   = 1'b0;
    bmem_write  = 1'b0;
    bmem_addr   = '0;
    bmem_wdata  = '0;
    case (r_state)
      IDLE: begin
        if (dfp_write) begin
          w_nextState = WR_DATA;
        end else if (dfp_read) begin
          w_nextState = RD_REQ;
        end
      end
      RD_REQ: begin
        bmem_read = 1'b1;
        bmem_addr = r_addr;
        if (bmem_ready) begin
          w_nextState = RD_DATA;
        end
      end
      RD_DATA: begin
        if (bmem_rvalid) begin
          w_beatDone = 1'b1;
          if (w_lastBeat) begin
            w_nextState = RESP;
          end
        end
      end
      WR_DATA: begin
        bmem_write = 1'b1;
        bmem_addr  = r_addr;
        bmem_wdata = r_wline[BEAT_WIDTH*int'(r_cnt) +: BEAT_WIDTH];
        if (bmem_ready) begin
          w_beatDone = 1'b1;
          if (w_lastBeat) begin
            w_nextState = RESP;
          end
        end
      end
      RESP: begin
        dfp_resp    = 1'b1;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Assembly buffer with the incoming beat merged into its slot.
  always_comb begin
    w_lineNext = r_rbuf;
    w_lineNext[BEAT_WIDTH*int'(r_cnt) +: BEAT_WIDTH] = bmem_rdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wline <= '0;
      r_rbuf  <= '0;
      r_rline <= '0;
    end else begin
      if (r_state == IDLE && (dfp_write || dfp_read)) begin
        r_addr <= dfp_addr & ADDR_MASK;
        if (dfp_write) begin
          r_wline <= dfp_wdata;
        end
      end
      if (w_beatDone) begin
        r_cnt <= w_lastBeat ? '0 : r_cnt + 1'b1;
      end
      // The visible line only changes once the whole new line has arrived.
      if (w_beatDone && r_state == RD_DATA) begin
        r_rbuf <= w_lineNext;
        if (w_lastBeat) begin
          r_rline <= w_lineNext;
        end
      end
    end
  end

endmodule

// File: tb/tb_cacheline_adapter.sv
// Scoreboard bench for cacheline_adapter: stimulus pushes expected memory
// traffic and responses, a negedge monitor pops and compares them.
module tb_cacheline_adapter;

  localparam int LINE_WIDTH = 256;
  localparam int BEAT_WIDTH = 64;
  localparam int BEATS      = LINE_WIDTH / BEAT_WIDTH;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [31:0]           dfp_addr;
  logic                  dfp_read;
  logic                  dfp_write;
  logic [LINE_WIDTH-1:0] dfp_wdata;
  logic [LINE_WIDTH-1:0] dfp_rdata;
  logic                  dfp_resp;
  logic [31:0]           bmem_addr;
  logic                  bmem_read;
  logic                  bmem_write;
  logic [BEAT_WIDTH-1:0] bmem_wdata;
  logic                  bmem_ready;
  logic [BEAT_WIDTH-1:0] bmem_rdata;
  logic                  bmem_rvalid;

  always #5 clk = ~clk;

  cacheline_adapter #(
    .LINE_WIDTH(LINE_WIDTH),
    .BEAT_WIDTH(BEAT_WIDTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dfp_addr   (dfp_addr),
    .dfp_read   (dfp_read),
    .dfp_write  (dfp_write),
    .dfp_wdata  (dfp_wdata),
    .dfp_rdata  (dfp_rdata),
    .dfp_resp   (dfp_resp),
    .bmem_addr  (bmem_addr),
    .bmem_read  (bmem_read),
    .bmem_write (bmem_write),
    .bmem_wdata (bmem_wdata),
    .bmem_ready (bmem_ready),
    .bmem_rdata (bmem_rdata),
    .bmem_rvalid(bmem_rvalid)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0]           expCmdQ[$];
  logic [31:0]           expWrAddrQ[$];
  logic [BEAT_WIDTH-1:0] expWrDataQ[$];
  logic [LINE_WIDTH-1:0] expRespQ[$];

  // Model state: the line the cache last received from a completed read.
  logic [LINE_WIDTH-1:0] lastLine;
  logic [BEAT_WIDTH-1:0] beatPlan[BEATS];
  int                    gapPlan[BEATS];
  logic [LINE_WIDTH-1:0] writeLine;
  int                    readyPlan[6] = '{1, 0, 1, 0, 1, 1};

  task automatic checkOutput(input string name, input logic [LINE_WIDTH-1:0] actual,
                             input logic [LINE_WIDTH-1:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic reportBad(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: got event/timeout expected none", name);
  endtask

  function automatic logic [31:0] alignOf(input logic [31:0] addr);
    return addr - (addr % (LINE_WIDTH / 8));
  endfunction

  function automatic logic [BEAT_WIDTH-1:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  // Monitor: compares whatever the DUT presents against the scoreboard heads.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bmem_read || bmem_write)
        checkOutput("rd_wr_exclusive", LINE_WIDTH'(bmem_read & bmem_write), '0);
      if (bmem_read) begin
        if (expCmdQ.size() == 0) reportBad("unexpected_bmem_read");
        else begin
          checkOutput("cmd_addr", LINE_WIDTH'(bmem_addr), LINE_WIDTH'(expCmdQ[0]));
          if (bmem_ready) void'(expCmdQ.pop_front());
        end
      end
      if (bmem_write) begin
        if (expWrDataQ.size() == 0) reportBad("unexpected_bmem_write");
        else begin
          checkOutput("wr_addr", LINE_WIDTH'(bmem_addr), LINE_WIDTH'(expWrAddrQ[0]));
          checkOutput("wr_data", LINE_WIDTH'(bmem_wdata), LINE_WIDTH'(expWrDataQ[0]));
          if (bmem_ready) begin
            void'(expWrAddrQ.pop_front());
            void'(expWrDataQ.pop_front());
          end
        end
      end
      if (dfp_resp) begin
        if (expRespQ.size() == 0) reportBad("unexpected_dfp_resp");
        else checkOutput("resp_line", dfp_rdata, expRespQ.pop_front());
      end
    end
  end

  task automatic doReset();
    rst_n       = 1'b0;
    dfp_read    = 1'b0;
    dfp_write   = 1'b0;
    bmem_ready  = 1'b0;
    bmem_rvalid = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst_dfp_resp",   LINE_WIDTH'(dfp_resp),   '0);
    checkOutput("rst_bmem_read",  LINE_WIDTH'(bmem_read),  '0);
    checkOutput("rst_bmem_write", LINE_WIDTH'(bmem_write), '0);
    checkOutput("rst_bmem_addr",  LINE_WIDTH'(bmem_addr),  '0);
    checkOutput("rst_bmem_wdata", LINE_WIDTH'(bmem_wdata), '0);
    checkOutput("rst_dfp_rdata",  dfp_rdata,               '0);
    rst_n = 1'b1;
    expCmdQ.delete();
    expWrAddrQ.delete();
    expWrDataQ.delete();
    expRespQ.delete();
    lastLine = '0;
  endtask

  task automatic waitResp(inout int cycles);
    int n = 0;
    while (dfp_resp !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      cycles++;
      n++;
    end
    if (dfp_resp !== 1'b1) begin
      reportBad("resp_timeout");
      doReset();
    end else begin
      @(posedge clk); #1;
      dfp_read  = 1'b0;
      dfp_write = 1'b0;
    end
  endtask

  task automatic readBurst(input logic [31:0] addr, input int stall, input int abortAfter,
                           output int cycles);
    logic [LINE_WIDTH-1:0] line = '0;
    int n = 0;
    for (int b = 0; b < BEATS; b++) line[b*BEAT_WIDTH +: BEAT_WIDTH] = beatPlan[b];
    expCmdQ.push_back(alignOf(addr));
    if (abortAfter < 0) begin
      expRespQ.push_back(line);
      lastLine = line;
    end
    dfp_addr  = addr;
    dfp_read  = 1'b1;
    dfp_write = 1'b0;
    cycles    = 0;
    do begin
      @(posedge clk); #1;
      cycles++;
      n++;
    end while (bmem_read !== 1'b1 && n < 20);
    if (bmem_read !== 1'b1) begin
      reportBad("read_cmd_timeout");
      doReset();
      return;
    end
    for (int s = 0; s < stall; s++) begin
      bmem_ready = 1'b0;
      @(posedge clk); #1;
      cycles++;
    end
    bmem_ready = 1'b1;
    @(posedge clk); #1;
    cycles++;
    bmem_ready = 1'b0;
    for (int b = 0; b < BEATS; b++) begin
      if (b == abortAfter) begin
        doReset();
        return;
      end
      for (int g = 0; g < gapPlan[b]; g++) begin
        bmem_rvalid = 1'b0;
        bmem_rdata  = rand64();
        @(posedge clk); #1;
        cycles++;
      end
      bmem_rvalid = 1'b1;
      bmem_rdata  = beatPlan[b];
      @(posedge clk); #1;
      cycles++;
    end
    bmem_rvalid = 1'b0;
    waitResp(cycles);
  endtask

  // readyMode: 0 always ready, 1 fixed toggle plan, 2 random.
  task automatic writeBurst(input logic [31:0] addr, input logic alsoRead, input logic stray,
                            input int readyMode, output int cycles);
    int n = 0;
    int accepted = 0;
    int idx = 0;
    logic r;
    for (int b = 0; b < BEATS; b++) begin
      expWrAddrQ.push_back(alignOf(addr));
      expWrDataQ.push_back(writeLine[b*BEAT_WIDTH +: BEAT_WIDTH]);
    end
    expRespQ.push_back(lastLine);
    dfp_addr  = addr;
    dfp_wdata = writeLine;
    dfp_write = 1'b1;
    dfp_read  = alsoRead;
    cycles    = 0;
    do begin
      @(posedge clk); #1;
      cycles++;
      n++;
    end while (bmem_write !== 1'b1 && n < 20);
    if (bmem_write !== 1'b1) begin
      reportBad("write_start_timeout");
      doReset();
      return;
    end
    n = 0;
    while (accepted < BEATS && n < 200) begin
      if (readyMode == 0) r = 1'b1;
      else if (readyMode == 1) r = (idx < 6) ? readyPlan[idx] != 0 : 1'b1;
      else r = $urandom_range(0, 1) != 0;
      idx++;
      bmem_ready  = r;
      bmem_rvalid = stray;
      bmem_rdata  = '1;
      @(posedge clk); #1;
      cycles++;
      n++;
      if (r) accepted++;
    end
    bmem_ready  = 1'b0;
    bmem_rvalid = 1'b0;
    waitResp(cycles);
  endtask

  task automatic idleCycles(input int k, input logic stray);
    for (int i = 0; i < k; i++) begin
      bmem_rvalid = stray;
      bmem_rdata  = '1;
      @(posedge clk); #1;
    end
    bmem_rvalid = 1'b0;
  endtask

  task automatic applyStimulus(input int kind, input logic [31:0] addr, output int cycles);
    if (kind == 0) begin
      for (int b = 0; b < BEATS; b++) begin
        beatPlan[b] = rand64();
        gapPlan[b]  = $urandom_range(0, 2);
      end
      readBurst(addr, $urandom_range(0, 3), -1, cycles);
    end else begin
      writeLine = {rand64(), rand64(), rand64(), rand64()};
      writeBurst(addr, kind == 2, $urandom_range(0, 1) != 0, 2, cycles);
    end
  endtask

  initial begin
    int cyc;
    dfp_addr    = '0;
    dfp_wdata   = '0;
    bmem_rdata  = '0;
    lastLine    = '0;
    doReset();

    beatPlan = '{ {16{4'h1}}, {16{4'h2}}, {16{4'h3}}, {16{4'h4}} };
    gapPlan  = '{0, 0, 0, 0};
    readBurst(32'h0000_1040, 0, -1, cyc);
    checkOutput("read_latency", LINE_WIDTH'(cyc), LINE_WIDTH'(6));
    checkOutput("read_line_held",  dfp_rdata,
                {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}});

    for (int b = 0; b < BEATS; b++) beatPlan[b] = rand64();
    gapPlan = '{0, 0, 2, 0};
    readBurst(32'h1234_567C, 3, -1, cyc);

    writeLine = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
    writeBurst(32'h0000_5000, 1'b0, 1'b0, 1, cyc);
    checkOutput("write_toggle_cycles", LINE_WIDTH'(cyc), LINE_WIDTH'(7));

    writeLine = {rand64(), rand64(), rand64(), rand64()};
    writeBurst(32'h0000_6010, 1'b0, 1'b0, 0, cyc);
    checkOutput("write_latency", LINE_WIDTH'(cyc), LINE_WIDTH'(5));

    writeLine = {rand64(), rand64(), rand64(), rand64()};
    writeBurst(32'h0000_7000, 1'b1, 1'b0, 0, cyc);

    for (int b = 0; b < BEATS; b++) beatPlan[b] = rand64();
    gapPlan = '{0, 0, 0, 0};
    readBurst(32'h0000_3000, 0, 2, cyc);
    for (int b = 0; b < BEATS; b++) beatPlan[b] = rand64();
    readBurst(32'h0000_2000, 1, -1, cyc);

    idleCycles(3, 1'b1);
    checkOutput("rdata_after_stray", dfp_rdata, lastLine);
    writeLine = {rand64(), rand64(), rand64(), rand64()};
    writeBurst(32'h0000_8000, 1'b0, 1'b1, 2, cyc);
    checkOutput("rdata_after_wr_stray", dfp_rdata, lastLine);
    for (int b = 0; b < BEATS; b++) beatPlan[b] = rand64();
    readBurst(32'h0000_9020, 0, -1, cyc);

    for (int t = 0; t < 40; t++) begin
      applyStimulus($urandom_range(0, 2), $urandom(), cyc);
      idleCycles($urandom_range(0, 2), $urandom_range(0, 1) != 0);
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("cmdq_drained",  LINE_WIDTH'(expCmdQ.size()),    '0);
    checkOutput("wrq_drained",   LINE_WIDTH'(expWrDataQ.size()), '0);
    checkOutput("respq_drained", LINE_WIDTH'(expRespQ.size()),   '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
